// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and lane geometry.
// Alignment helpers are consumed only when LSU_ALIGN_CHECK_EN is defined.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   localparam int WORD_W = 32;
   localparam int HALF_W = 16;
   localparam int BYTE_W = 8;
   localparam int LANES  = WORD_W / BYTE_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } lsu_state_e;

   // The illegal encoding behaves as a word access when alignment checking is off.
   function automatic logic [1:0] eff_size(input logic [1:0] sz);
      return (sz == SZ_ILL) ? SZ_WORD : sz;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] offs);
      logic bad;
      case (sz)
         SZ_HALF: bad = offs[0];
         SZ_WORD: bad = (offs != 2'b00);
         SZ_ILL:  bad = 1'b1;
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: little-endian extract + sign/zero extend for loads,
// and byte/half insertion into a fetched word for sub-word stores.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]        i_size,
   input  logic [1:0]        i_offs,
   input  logic              i_unsigned,
   input  logic [WORD_W-1:0] i_rdata,
   input  logic [WORD_W-1:0] i_wdata,
   output logic [WORD_W-1:0] o_load_data,
   output logic [WORD_W-1:0] o_merge_data
);

   logic [BYTE_W-1:0] w_byte;
   logic [HALF_W-1:0] w_half;
   logic              w_bsign;
   logic              w_hsign;

   always_comb begin
      case (i_offs)
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         2'd3:    w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
      w_half  = i_offs[1] ? i_rdata[31:16] : i_rdata[15:0];
      w_bsign = w_byte[BYTE_W-1] & ~i_unsigned;
      w_hsign = w_half[HALF_W-1] & ~i_unsigned;
   end

   always_comb begin
      case (i_size)
         SZ_BYTE: o_load_data = {{(WORD_W-BYTE_W){w_bsign}}, w_byte};
         SZ_HALF: o_load_data = {{(WORD_W-HALF_W){w_hsign}}, w_half};
         default: o_load_data = i_rdata;
      endcase
   end

   // Lanes not written keep the value just fetched from memory.
   always_comb begin
      o_merge_data = i_rdata;
      case (i_size)
         SZ_BYTE: o_merge_data[BYTE_W*i_offs +: BYTE_W]    = i_wdata[BYTE_W-1:0];
         SZ_HALF: o_merge_data[HALF_W*i_offs[1] +: HALF_W] = i_wdata[HALF_W-1:0];
         default: o_merge_data = i_wdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit driving a word-only data memory; sub-word stores use read-modify-write.
// Define LSU_ALIGN_CHECK_EN to reject misaligned half/word and illegal-size requests.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              reqValid,
   output logic              reqReady,
   input  logic              reqWrite,
   input  logic [1:0]        reqSize,
   input  logic              reqUnsigned,
   input  logic [ADDR_W-1:0] reqAddr,
   input  logic [DATA_W-1:0] reqWdata,
   output logic              respValid,
   output logic [DATA_W-1:0] respRdata,
   output logic              misalignErr,
   output logic [ADDR_W-1:0] memAddress,
   output logic [DATA_W-1:0] memWriteData,
   input  logic [DATA_W-1:0] memReadData,
   output logic              memRead,
   output logic              memWrite
);

   lsu_state_e        r_state;
   lsu_state_e        w_state_nxt;

   logic              r_write;
   logic [1:0]        r_size;
   logic              r_unsigned;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_err;

   logic              w_accept;
   logic              w_err;
   logic [1:0]        w_size;
   logic [DATA_W-1:0] w_load;
   logic [DATA_W-1:0] w_merge;

`ifdef LSU_ALIGN_CHECK_EN
   assign w_err = is_misaligned(reqSize, reqAddr[1:0]);
`else
   assign w_err = 1'b0;
`endif

   assign w_size   = eff_size(reqSize);
   assign w_accept = reqValid & (r_state == ST_IDLE);

   lsu_lane_align u_align (
      .i_size       (r_size),
      .i_offs       (r_addr[1:0]),
      .i_unsigned   (r_unsigned),
      .i_rdata      (memReadData),
      .i_wdata      (r_wdata),
      .o_load_data  (w_load),
      .o_merge_data (w_merge)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Strobes decode from the registered state only, so an async reset drops them at once.
   always_comb begin
      w_state_nxt = r_state;
      reqReady    = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      respValid   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            reqReady = 1'b1;
            if (reqValid) begin
               if (w_err) begin
                  w_state_nxt = ST_RESP;
               end else if (reqWrite && (w_size == SZ_WORD)) begin
                  w_state_nxt = ST_WRITE;
               end else begin
                  w_state_nxt = ST_READ;
               end
            end
         end
         ST_READ: begin
            memRead     = 1'b1;
            w_state_nxt = r_write ? ST_WRITE : ST_RESP;
         end
         ST_WRITE: begin
            memWrite    = 1'b1;
            w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            respValid   = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // r_wdata holds the raw store data until READ replaces it with the merged word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_write    <= 1'b0;
         r_size     <= SZ_BYTE;
         r_unsigned <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_err      <= 1'b0;
      end else if (w_accept) begin
         r_write    <= reqWrite;
         r_size     <= w_size;
         r_unsigned <= reqUnsigned;
         r_addr     <= reqAddr;
         r_wdata    <= reqWdata;
         r_rdata    <= '0;
         r_err      <= w_err;
      end else if (r_state == ST_READ) begin
         if (r_write) begin
            r_wdata <= w_merge;
         end else begin
            r_rdata <= w_load;
         end
      end
   end

   assign memAddress   = {r_addr[ADDR_W-1:2], 2'b00};
   assign memWriteData = r_wdata;
   assign respRdata    = r_rdata;
   assign misalignErr  = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of load/store vectors against a small
// word memory, plus hand-written reset-during-write and reset-state sequences.
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        reqValid;
   logic        reqReady;
   logic        reqWrite;
   logic [1:0]  reqSize;
   logic        reqUnsigned;
   logic [31:0] reqAddr;
   logic [31:0] reqWdata;
   logic        respValid;
   logic [31:0] respRdata;
   logic        misalignErr;
   logic [31:0] memAddress;
   logic [31:0] memWriteData;
   logic [31:0] memReadData;
   logic        memRead;
   logic        memWrite;

   int n_tests;
   int n_fail;

   load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .reqValid     (reqValid),
      .reqReady     (reqReady),
      .reqWrite     (reqWrite),
      .reqSize      (reqSize),
      .reqUnsigned  (reqUnsigned),
      .reqAddr      (reqAddr),
      .reqWdata     (reqWdata),
      .respValid    (respValid),
      .respRdata    (respRdata),
      .misalignErr  (misalignErr),
      .memAddress   (memAddress),
      .memWriteData (memWriteData),
      .memReadData  (memReadData),
      .memRead      (memRead),
      .memWrite     (memWrite)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [0:15];
   logic        preload;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
         mem[4] <= 32'h8899AABB;
      end else if (memWrite) begin
         mem[memAddress[5:2]] <= memWriteData;
      end
   end

   assign memReadData = mem[memAddress[5:2]];

   typedef struct {
      string       name;
      logic        wr;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
      int          exp_nrd;
      int          exp_nwr;
      logic        chk_mem;
      logic [31:0] exp_mem;
      logic        hold;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string nm, input logic wr, input logic [1:0] sz,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] exp_rd, input logic exp_err, input int lat,
                               input int nrd, input int nwr, input logic chk_mem,
                               input logic [31:0] exp_mem, input logic hold);
      vec_t v;
      v.name = nm; v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd;
      v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = lat; v.exp_nrd = nrd;
      v.exp_nwr = nwr; v.chk_mem = chk_mem; v.exp_mem = exp_mem; v.hold = hold;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int          lat, nrd, nwr, both, bad_addr, guard;
      logic        got;
      logic [31:0] rd;
      logic        err;
      guard = 0;
      @(negedge clk);
      while (!reqReady && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk({v.name, ":ready"}, {31'b0, reqReady}, 32'd1);
      reqValid    = 1'b1;
      reqWrite    = v.wr;
      reqSize     = v.sz;
      reqUnsigned = v.uns;
      reqAddr     = v.addr;
      reqWdata    = v.wd;
      @(posedge clk);
      #1;
      if (v.hold) begin
         reqWrite = ~v.wr;
         reqAddr  = 32'h0000_0020;
         reqWdata = 32'hFFFF_FFFF;
         reqSize  = 2'b00;
      end else begin
         reqValid = 1'b0;
      end
      lat = 0; nrd = 0; nwr = 0; both = 0; bad_addr = 0;
      got = 1'b0; rd = 32'hDEAD_DEAD; err = 1'bx;
      while (!got && lat < 8) begin
         lat++;
         if (memRead) nrd++;
         if (memWrite) nwr++;
         if (memRead && memWrite) both++;
         if ((memRead || memWrite) && memAddress != {v.addr[31:2], 2'b00}) bad_addr++;
         if (respValid) begin
            got = 1'b1;
            rd  = respRdata;
            err = misalignErr;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      reqValid = 1'b0;
      chk({v.name, ":latency"}, lat, v.exp_lat);
      chk({v.name, ":rdata"}, rd, v.exp_rd);
      chk({v.name, ":misalign"}, {31'b0, err}, {31'b0, v.exp_err});
      chk({v.name, ":reads"}, nrd, v.exp_nrd);
      chk({v.name, ":writes"}, nwr, v.exp_nwr);
      chk({v.name, ":overlap"}, both, 0);
      chk({v.name, ":addr"}, bad_addr, 0);
      if (v.chk_mem) chk({v.name, ":mem"}, mem[v.addr[5:2]], v.exp_mem);
      if (v.hold) begin
         @(posedge clk);
         #1;
         chk({v.name, ":idle_after"}, {30'b0, reqReady, respValid}, 32'd2);
      end
   endtask

   initial begin
      logic [31:0] saved;
      int          pulses;
      n_tests = 0;
      n_fail  = 0;
      reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00; reqUnsigned = 1'b0;
      reqAddr = 32'h0; reqWdata = 32'h0;
      rst_n   = 1'b0;
      preload = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst:reqReady", {31'b0, reqReady}, 32'd1);
      chk("rst:strobes", {29'b0, respValid, memRead, memWrite}, 32'd0);
      chk("rst:misalign", {31'b0, misalignErr}, 32'd0);
      chk("rst:respRdata", respRdata, 32'h0);
      chk("rst:memAddress", memAddress, 32'h0);
      chk("rst:memWriteData", memWriteData, 32'h0);
      @(negedge clk);
      rst_n   = 1'b1;
      preload = 1'b0;

      //                 name        wr    sz     uns   addr   wdata          exp_rd        err lat rd wr chk  exp_mem       hold
      vecs.push_back(mk("lw_10",    1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h8899AABB, 0, 2, 1, 0, 1'b0, 32'h0,        1'b0));
      vecs.push_back(mk("lb_11",    1'b0, 2'b00, 1'b0, 32'h11, 32'h0,        32'hFFFFFFAA, 0, 2, 1, 0, 1'b0, 32'h0,        1'b0));
      vecs.push_back(mk("lbu_13",   1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'h00000088, 0, 2, 1, 0, 1'b0, 32'h0,        1'b0));
      vecs.push_back(mk("lh_12",    1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'hFFFF8899, 0, 2, 1, 0, 1'b0, 32'h0,        1'b0));
      vecs.push_back(mk("lhu_10",   1'b0, 2'b01, 1'b1, 32'h10, 32'h0,        32'h0000AABB, 0, 2, 1, 0, 1'b0, 32'h0,        1'b0));
`ifdef LSU_ALIGN_CHECK_EN
      vecs.push_back(mk("lh_13",    1'b0, 2'b01, 1'b0, 32'h13, 32'h0,        32'h0,        1, 1, 0, 0, 1'b0, 32'h0,        1'b0));
`else
      vecs.push_back(mk("lh_13",    1'b0, 2'b01, 1'b0, 32'h13, 32'h0,        32'hFFFF8899, 0, 2, 1, 0, 1'b0, 32'h0,        1'b0));
`endif
      vecs.push_back(mk("sb_12",    1'b1, 2'b00, 1'b0, 32'h12, 32'h000000CC, 32'h0,        0, 3, 1, 1, 1'b1, 32'h88CCAABB, 1'b0));
      vecs.push_back(mk("lb_12",    1'b0, 2'b00, 1'b0, 32'h12, 32'h0,        32'hFFFFFFCC, 0, 2, 1, 0, 1'b0, 32'h0,        1'b0));
      vecs.push_back(mk("sw_20",    1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 32'h0,        0, 2, 0, 1, 1'b1, 32'hDEADBEEF, 1'b0));
      vecs.push_back(mk("lbu_23",   1'b0, 2'b00, 1'b1, 32'h23, 32'h0,        32'h000000DE, 0, 2, 1, 0, 1'b0, 32'h0,        1'b0));
      vecs.push_back(mk("lb_21",    1'b0, 2'b00, 1'b0, 32'h21, 32'h0,        32'hFFFFFFBE, 0, 2, 1, 0, 1'b0, 32'h0,        1'b0));
      vecs.push_back(mk("sh_22",    1'b1, 2'b01, 1'b0, 32'h22, 32'hABCD1234, 32'h0,        0, 3, 1, 1, 1'b1, 32'h1234BEEF, 1'b0));
      vecs.push_back(mk("lhu_22",   1'b0, 2'b01, 1'b1, 32'h22, 32'h0,        32'h00001234, 0, 2, 1, 0, 1'b0, 32'h0,        1'b0));
`ifdef LSU_ALIGN_CHECK_EN
      vecs.push_back(mk("ill_20",   1'b0, 2'b11, 1'b0, 32'h20, 32'h0,        32'h0,        1, 1, 0, 0, 1'b0, 32'h0,        1'b0));
      vecs.push_back(mk("lw_21",    1'b0, 2'b10, 1'b0, 32'h21, 32'h0,        32'h0,        1, 1, 0, 0, 1'b0, 32'h0,        1'b0));
`else
      vecs.push_back(mk("ill_20",   1'b0, 2'b11, 1'b0, 32'h20, 32'h0,        32'h1234BEEF, 0, 2, 1, 0, 1'b0, 32'h0,        1'b0));
      vecs.push_back(mk("lw_21",    1'b0, 2'b10, 1'b0, 32'h21, 32'h0,        32'h1234BEEF, 0, 2, 1, 0, 1'b0, 32'h0,        1'b0));
`endif
      vecs.push_back(mk("lw_hold",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h88CCAABB, 0, 2, 1, 0, 1'b0, 32'h0,        1'b1));
      vecs.push_back(mk("sb_hold",  1'b1, 2'b00, 1'b0, 32'h20, 32'h00000077, 32'h0,        0, 3, 1, 1, 1'b1, 32'h1234BE77, 1'b1));

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

      // Reset while the merged halfword is being written: no write, no response.
      saved = mem[4];
      @(negedge clk);
      chk("rstw:ready", {31'b0, reqReady}, 32'd1);
      reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b01; reqUnsigned = 1'b0;
      reqAddr = 32'h10; reqWdata = 32'h00001234;
      @(posedge clk);
      #1;
      reqValid = 1'b0;
      chk("rstw:read_phase", {31'b0, memRead}, 32'd1);
      @(posedge clk);
      #1;
      chk("rstw:write_phase", {31'b0, memWrite}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rstw:write_drop", {31'b0, memWrite}, 32'd0);
      chk("rstw:ready_now", {31'b0, reqReady}, 32'd1);
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         if (respValid) pulses++;
         if (c == 1) begin
            @(negedge clk);
            rst_n = 1'b1;
         end
      end
      chk("rstw:mem_unchanged", mem[4], saved);
      chk("rstw:no_resp", pulses, 0);
      chk("rstw:ready_after", {31'b0, reqReady}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, %0d tests run", n_tests);
      $fatal(1);
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator side of the single-cycle datapath's word-addressed data memory port (memRead/memWrite/address/writeData/readData); the memory itself is the responder.
- Accepts byte, halfword and word load/store requests from the core through a valid/ready handshake.
- Drives the memory strobes and performs read-modify-write for sub-word stores, because the memory writes whole words only.
- Returns sign- or zero-extended load data through a one-cycle response pulse.

Parameters:
ADDR_W, 32, byte-address width of request and memory address.
DATA_W, 32, data width; only 32 is supported.

Ports:
clk  in  1  clock; memory writes on the same rising edge.
rst_n  in  1  asynchronous active-low reset.
reqValid  in  1  core request valid.
reqReady  out  1  unit can accept a request (high only in IDLE).
reqWrite  in  1  1 = store, 0 = load.
reqSize  in  2  00 byte, 01 half, 10 word, 11 illegal.
reqUnsigned  in  1  zero-extend loads when 1.
reqAddr  in  ADDR_W  byte address.
reqWdata  in  DATA_W  store data, right-aligned.
respValid  out  1  one-cycle completion pulse.
respRdata  out  DATA_W  extended load data; 0 for stores and errors.
misalignErr  out  1  qualified by respValid.
memAddress  out  ADDR_W  word-aligned address {addr[31:2],2'b00}.
memWriteData  out  DATA_W  merged word to write.
memReadData  in  DATA_W  combinational read data, valid in the same cycle as memRead.
memRead  out  1  read strobe.
memWrite  out  1  write strobe.

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP. All outputs decode from the registered state and latched request.
- Reset values: state IDLE, reqReady=1, respValid=0, misalignErr=0, respRdata=0, memRead=0, memWrite=0, memAddress=0, memWriteData=0.
- IDLE: reqReady=1. On reqValid&reqReady, latch the request, then go to:
  - RESP with error if misaligned (see feature) or reqSize=11; no memory access.
  - READ for a load.
  - WRITE for a word store.
  - READ for a byte/half store (fetch the word to merge into).
- READ: memRead=1 for exactly one cycle. memReadData is registered at the edge.
  - Load: extract lanes, extend, go to RESP.
  - Store: merge reqWdata into the fetched lanes, go to WRITE.
- WRITE: memWrite=1 for exactly one cycle with the merged word (or reqWdata for sw), then go to RESP.
- RESP: respValid=1 for one cycle, then go to IDLE. Back-to-back requests are accepted one cycle after RESP.
- memRead and memWrite are never high together and are 0 in IDLE and RESP.
- Lanes are little-endian: byte k = word[8k+7:8k] at addr[1:0]=k; half at addr[1]=h is word[16h+15:16h]. Untouched lanes keep their read value.
- Latency from accept edge to the respValid cycle:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- Reset mid-operation aborts immediately. Strobes drop asynchronously, so no memory write occurs at the next edge. No response is issued.
- reqValid while reqReady=0 is ignored; request fields are sampled only at accept.

Optional Feature:
LSU_ALIGN_CHECK_EN.
- Defined: a half with addr[0]=1, or a word with addr[1:0]!=0, returns respValid with misalignErr=1 and no memory strobes.
- Undefined: misalignErr is tied to 0; half ignores addr[0] and word ignores addr[1:0]. reqSize=11 is treated as word.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - the FSM state enum
  - lane/width constants
- Sub-module lsu_lane_align (combinational) holds:
  - extract + sign/zero extend for loads
  - byte/half merge for stores
- The top module holds the FSM and registers.

Test Plan:
Test memory preloaded with word 0x10 = 0x8899AABB.
1. lw 0x10 -> memRead high for 1 cycle at memAddress 0x10; respValid 2 cycles after accept; respRdata=0x8899AABB.
2. lb 0x11 -> 0xFFFFFFAA; lbu 0x13 -> 0x00000088; lh 0x12 -> 0xFFFF8899; lhu 0x10 -> 0x0000AABB.
3. sb 0x12 with data 0xCC -> memRead 1 cycle, then memWrite 1 cycle with 0x88CCAABB; respValid 3 cycles after accept; respRdata=0.
4. sw 0x20 with 0xDEADBEEF -> no memRead, memWrite 1 cycle; mem[0x20]=0xDEADBEEF; respValid 2 cycles after accept.
5. lh 0x13:
   - with LSU_ALIGN_CHECK_EN -> respValid with misalignErr=1 one cycle after accept, no strobes.
   - without it -> reads half at 0x12 = 0xFFFF8899.
6. sh 0x10 with 0x1234, rst_n low during WRITE -> memWrite falls immediately, mem[0x10] unchanged, reqReady=1, respValid never pulses.
